// File: rtl/adc_frame_align_ctrl.sv
// adc_frame_align_ctrl: walks the ADC deserializers one at a time, compares the
// frame-clock word against the fixed frame pattern and issues bitslip pulses
// until the word locks or the per-ADC slip budget is exhausted.
// Optional build macro FRAME_MONITOR_EN adds a post-alignment frame monitor
// (FRAME_LOSS sticky flags and a saturating LOSS_CNT).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for START; frame monitor active when a pass is done
// S_SETTLE | deserializer settling after ADC select or bitslip
// S_CHECK  | comparing CUR_ADC word to PATTERN, counting consecutive hits
// S_SLIP   | one-cycle bitslip pulse to CUR_ADC
// S_NEXT   | advance to the next ADC or wrap up the pass
// S_FINISH | drop BUSY, raise ALIGN_DONE
module adc_frame_align_ctrl #(
  parameter int               NADC      = 12,
  parameter int               WBITS     = 12,
  parameter logic [WBITS-1:0] PATTERN   = 12'hFC0,
  parameter int               SETTLE    = 4,
  parameter int               MATCH_CNT = 8,
  parameter int               MAX_SLIP  = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [NADC*WBITS-1:0] frame_word_i,
  output logic [NADC-1:0]       bitslip_o,
  output logic                  busy_o,
  output logic                  align_done_o,
  output logic [NADC-1:0]       aligned_o,
  output logic [NADC-1:0]       align_err_o,
`ifdef FRAME_MONITOR_EN
  output logic [NADC-1:0]       frame_loss_o,
  output logic [15:0]           loss_cnt_o,
`endif
  output logic [3:0]            cur_adc_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_NEXT, S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  logic [3:0]      match_q, match_d;
  logic [3:0]      slip_q, slip_d;
  logic [3:0]      cur_q, cur_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NADC-1:0] aligned_q, aligned_d;
  logic [NADC-1:0] err_q, err_d;
  logic            word_match;

  assign word_match = (frame_word_i[int'(cur_q)*WBITS +: WBITS] == PATTERN);

`ifdef FRAME_MONITOR_EN
  logic [NADC-1:0] loss_q, loss_d;
  logic [15:0]     loss_cnt_q, loss_cnt_d;
  logic [NADC-1:0] word_ne;

  // per-ADC mismatch vector used by the idle frame monitor
  always_comb begin
    word_ne = '0;
    for (int i = 0; i < NADC; i++) begin
      word_ne[i] = (frame_word_i[i*WBITS +: WBITS] != PATTERN);
    end
  end
`endif

  // next-state and output decode for the alignment sequencer
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    match_d   = match_q;
    slip_d    = slip_q;
    cur_d     = cur_q;
    busy_d    = busy_q;
    done_d    = done_q;
    aligned_d = aligned_q;
    err_d     = err_q;
    bitslip_o = '0;
`ifdef FRAME_MONITOR_EN
    loss_d     = loss_q;
    loss_cnt_d = loss_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          busy_d    = 1'b1;
          done_d    = 1'b0;
          aligned_d = '0;
          err_d     = '0;
          cur_d     = '0;
          slip_d    = '0;
          match_d   = '0;
          wait_d    = 4'(SETTLE);
          state_d   = S_SETTLE;
`ifdef FRAME_MONITOR_EN
          loss_d     = '0;
          loss_cnt_d = '0;
`endif
        end
`ifdef FRAME_MONITOR_EN
        else if (done_q) begin
          loss_d = loss_q | (aligned_q & word_ne);
          if (|(aligned_q & word_ne) && loss_cnt_q != 16'hFFFF) begin
            loss_cnt_d = loss_cnt_q + 16'd1;
          end
        end
`endif
      end
      S_SETTLE: begin
        if (wait_q <= 4'd1) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_CHECK: begin
        if (word_match) begin
          match_d = match_q + 4'd1;
          if (match_q + 4'd1 == 4'(MATCH_CNT)) begin
            aligned_d[cur_q] = 1'b1;
            state_d          = S_NEXT;
          end
        end else begin
          match_d = '0;
          if (slip_q < 4'(MAX_SLIP)) begin
            state_d = S_SLIP;
          end else begin
            err_d[cur_q] = 1'b1;
            state_d      = S_NEXT;
          end
        end
      end
      S_SLIP: begin
        bitslip_o[cur_q] = 1'b1;
        if (slip_q != 4'hF) slip_d = slip_q + 4'd1;
        wait_d  = 4'(SETTLE);
        state_d = S_SETTLE;
      end
      S_NEXT: begin
        if (cur_q == 4'(NADC-1)) begin
          state_d = S_FINISH;
        end else begin
          cur_d   = cur_q + 4'd1;
          slip_d  = '0;
          match_d = '0;
          wait_d  = 4'(SETTLE);
          state_d = S_SETTLE;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      match_q   <= '0;
      slip_q    <= '0;
      cur_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aligned_q <= '0;
      err_q     <= '0;
`ifdef FRAME_MONITOR_EN
      loss_q     <= '0;
      loss_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      cur_q     <= cur_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aligned_q <= aligned_d;
      err_q     <= err_d;
`ifdef FRAME_MONITOR_EN
      loss_q     <= loss_d;
      loss_cnt_q <= loss_cnt_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign align_done_o = done_q;
  assign aligned_o    = aligned_q;
  assign align_err_o  = err_q;
  assign cur_adc_o    = cur_q;
`ifdef FRAME_MONITOR_EN
  assign frame_loss_o = loss_q;
  assign loss_cnt_o   = loss_cnt_q;
`endif

endmodule

// File: doc/adc_frame_align_ctrl.md
Name: adc_frame_align_ctrl

Overview:
- Sequences word alignment of the 12 ADC deserializers: 6 groups x 2 ADCs, each with its own frame clock and bit clock.
- Walks the ADCs one at a time. Compares each deserialized frame-clock word to the fixed frame pattern and issues bitslip pulses until the word locks or the slip budget runs out.
- Sits between the ADC input/deserializer layer and DAQ readout. Readout is gated by ALIGN_DONE and ALIGNED.

Parameters:
- NADC, 12, number of ADCs (6 groups x 2).
- WBITS, 12, deserialized word width per ADC.
- PATTERN, 12'hFC0, expected frame-clock word when aligned.
- SETTLE, 4, cycles to wait after selecting an ADC or after a bitslip, before comparing (range 1..15).
- MATCH_CNT, 8, consecutive matching cycles needed to declare lock (range 1..15).
- MAX_SLIP, 12, bitslips allowed per ADC before it is declared failed.

Ports:
- CLK  in  1  system clock; FRAME_WORD is already synchronous to it.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; starts a full alignment pass.
- FRAME_WORD  in  NADC*WBITS  deserialized frame-clock words; ADC i occupies bits [i*WBITS +: WBITS]; index = 2*(group-1) + adc.
- BITSLIP  out  NADC  one-hot, one-cycle bitslip request to ADC i's deserializer.
- BUSY  out  1  high while a pass is in progress.
- ALIGN_DONE  out  1  high after a pass completes; cleared by START or RST.
- ALIGNED  out  NADC  per-ADC lock flag.
- ALIGN_ERR  out  NADC  per-ADC failure flag (slip budget exhausted).
- CUR_ADC  out  4  index of the ADC being processed (debug).

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- FSM states: IDLE, SETTLE, CHECK, SLIP, NEXT, FINISH.
- IDLE:
  - On START: BUSY=1, ALIGN_DONE=0, ALIGNED=0, ALIGN_ERR=0, CUR_ADC=0, slip_cnt=0, then go to SETTLE.
  - START in any other state is ignored.
- SETTLE:
  - Wait counter loads SETTLE on entry.
  - Go to CHECK after exactly SETTLE cycles in SETTLE.
- CHECK, compare the word of CUR_ADC each cycle:
  - Match: match_cnt increments. When match_cnt reaches MATCH_CNT, set ALIGNED[CUR_ADC]=1 and go to NEXT.
  - Mismatch, slip_cnt < MAX_SLIP: match_cnt=0, go to SLIP.
  - Mismatch, slip_cnt == MAX_SLIP: set ALIGN_ERR[CUR_ADC]=1 and go to NEXT.
- SLIP:
  - One cycle with BITSLIP[CUR_ADC]=1; all other BITSLIP bits stay 0.
  - slip_cnt increments, then go to SETTLE.
  - BITSLIP is never high for two consecutive cycles.
- NEXT:
  - If CUR_ADC == NADC-1, go to FINISH.
  - Otherwise CUR_ADC increments, slip_cnt=0, match_cnt=0, go to SETTLE.
- FINISH: BUSY=0, ALIGN_DONE=1, go to IDLE. ALIGNED and ALIGN_ERR hold until the next START or RST.
- Exclusivity: ALIGNED[i] and ALIGN_ERR[i] are never both 1.
- Pass-time bounds:
  - Best case per ADC: SETTLE + MATCH_CNT cycles in SETTLE/CHECK, plus 1 NEXT cycle.
  - Worst case per ADC: MAX_SLIP slips.
  - Counters are sized to saturate, never wrap: slip_cnt 4 bits, match_cnt 4 bits.
- A mismatch after a partial match run resets match_cnt. Lock always requires MATCH_CNT consecutive matches.
- RST mid-pass: on the next edge, return to IDLE with all outputs 0. No BITSLIP pulse is issued in that cycle.

Optional Feature:
- Macro: FRAME_MONITOR_EN.
- With the macro defined:
  - While in IDLE with ALIGN_DONE=1, every ADC with ALIGNED[i]=1 is compared to PATTERN every cycle.
  - Any mismatch sets sticky output FRAME_LOSS[NADC-1:0] bit i.
  - A 16-bit saturating LOSS_CNT counts cycles in which any bit mismatches.
  - Both are cleared by START or RST.
- Without the macro: the FRAME_LOSS and LOSS_CNT ports and their logic are absent. Behaviour is otherwise identical.

Test Plan:
- Already aligned: all words = 12'hFC0, pulse START.
  - Expect no BITSLIP pulses; ALIGNED = 12'hFFF; ALIGN_ERR = 0.
  - ALIGN_DONE rises 12*(4+8+1)+1 = 157 cycles after START.
- Misaligned ADC 5: word rotated by 3 bits, bench model rotates back one bit per BITSLIP[5] pulse.
  - Expect exactly 3 pulses on BITSLIP[5], each followed by 4 settle cycles.
  - Final state: ALIGNED[5] = 1, ALIGN_ERR = 0.
- Dead ADC 11: word stuck at 12'h000.
  - Expect 12 BITSLIP[11] pulses, then ALIGN_ERR[11] = 1 and ALIGNED[11] = 0; ALIGN_DONE = 1.
- Glitch during match run: ADC 0 matches 5 cycles, mismatches 1 cycle, then matches.
  - Expect 1 slip, with the match count restarting.
  - Bench model does not rotate on that slip; expect lock after 8 further matching cycles.
- RST mid-pass: assert RST while in SLIP for ADC 3.
  - Expect all outputs 0 next cycle and BUSY = 0.
  - A new START begins again at CUR_ADC = 0.
- FRAME_MONITOR_EN: after a clean pass, corrupt ADC 7 for 2 cycles.
  - Expect FRAME_LOSS[7] = 1 (sticky) and LOSS_CNT = 2.
  - START clears both.
